mem_access_ctrl: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/sat_counter.sv | 31 +++
 rtl/mem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the CPU control path: memory-access sequencer states and op encodings.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mac_state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, async clear to zero.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Runs one RAM load or store through MAR/MDR for the control unit and pulses done when finished.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int RAM_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_valid,
    input  logic             req_write,
    output logic             req_ready,
    output logic             data_req,
    output logic             MARin,
    output logic             MDRin,
    output logic             Read,
    output logic             Write,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] load_count,
    output logic [CNT_W-1:0] store_count
);

    localparam logic [3:0] LAT_LAST = 4'(RAM_LATENCY - 1);

    mac_state_t state_q;
    mac_state_t state_d;
    logic [3:0] lat_cnt_q;
    logic [3:0] lat_cnt_d;
    logic       op_is_write_q;
    logic       op_is_write_d;
    logic       accept;
    logic       lat_last;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign lat_last  = (lat_cnt_q == LAT_LAST);

    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        op_is_write_d = op_is_write_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_is_write_d = req_write;
                    lat_cnt_d     = '0;
                    state_d       = (req_write == OP_STORE) ? DATA : ACCESS;
                end
            end
            DATA: begin
                lat_cnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (lat_last) begin
                    lat_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            op_is_write_q <= OP_LOAD;
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            op_is_write_q <= op_is_write_d;
        end
    end

    // Everything but MARin/req_ready decodes registered state only, so no input-to-strobe paths.
    always_comb begin
        MARin    = accept;
        data_req = 1'b0;
        MDRin    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        done     = 1'b0;
        busy     = (state_q != IDLE);
        unique case (state_q)
            DATA: begin
                data_req = 1'b1;
                MDRin    = 1'b1;
            end
            ACCESS: begin
                if (op_is_write_q == OP_STORE) begin
                    Write = 1'b1;
                end else begin
                    Read  = 1'b1;
                    MDRin = lat_last;
                end
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_load_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (done && (op_is_write_q == OP_LOAD)),
        .q     (load_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_store_cnt (
        .clock (clock),
        .clear (clear),
        .inc   (done && (op_is_write_q == OP_STORE)),
        .q     (store_count)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (latency 3 / 2-bit counters, latency 1 / 16-bit counters) with a MAR/MDR/RAM model each.
module tb_mem_access_ctrl;

    logic        clock;
    logic        clear;
    logic [31:0] bus;

    logic        req_valid_a, req_write_a;
    logic        req_ready_a, data_req_a, MARin_a, MDRin_a, Read_a, Write_a, done_a, busy_a;
    logic [1:0]  load_count_a, store_count_a;

    logic        req_valid_b, req_write_b;
    logic        req_ready_b, data_req_b, MARin_b, MDRin_b, Read_b, Write_b, done_b, busy_b;
    logic [15:0] load_count_b, store_count_b;

    mem_access_ctrl #(.RAM_LATENCY(3), .CNT_W(2)) dut_a (
        .clock(clock), .clear(clear),
        .req_valid(req_valid_a), .req_write(req_write_a), .req_ready(req_ready_a),
        .data_req(data_req_a), .MARin(MARin_a), .MDRin(MDRin_a), .Read(Read_a), .Write(Write_a),
        .done(done_a), .busy(busy_a), .load_count(load_count_a), .store_count(store_count_a)
    );

    mem_access_ctrl #(.RAM_LATENCY(1), .CNT_W(16)) dut_b (
        .clock(clock), .clear(clear),
        .req_valid(req_valid_b), .req_write(req_write_b), .req_ready(req_ready_b),
        .data_req(data_req_b), .MARin(MARin_b), .MDRin(MDRin_b), .Read(Read_b), .Write(Write_b),
        .done(done_b), .busy(busy_b), .load_count(load_count_b), .store_count(store_count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath model: MAR, MDR and a small RAM behind each instance
    logic [7:0]  mar_a, mar_b;
    logic [31:0] mdr_a, mdr_b;
    logic [31:0] ram_a [0:255];
    logic [31:0] ram_b [0:255];

    always @(posedge clock) begin
        if (clear) begin
            mar_a <= 8'h0;
            mdr_a <= 32'h0;
            ram_a[8'h20] <= 32'hDEADBEEF;
            mar_b <= 8'h0;
            mdr_b <= 32'h0;
            ram_b[8'h20] <= 32'hDEADBEEF;
        end else begin
            if (MARin_a) mar_a <= bus[7:0];
            if (MDRin_a) mdr_a <= Read_a ? ram_a[mar_a] : bus;
            if (Write_a) ram_a[mar_a] <= mdr_a;
            if (MARin_b) mar_b <= bus[7:0];
            if (MDRin_b) mdr_b <= Read_b ? ram_b[mar_b] : bus;
            if (Write_b) ram_b[mar_b] <= mdr_b;
        end
    end

    // Packed view: {req_ready, data_req, MARin, MDRin, Read, Write, done, busy}
    logic [7:0] obs_a, obs_b;
    assign obs_a = {req_ready_a, data_req_a, MARin_a, MDRin_a, Read_a, Write_a, done_a, busy_a};
    assign obs_b = {req_ready_b, data_req_b, MARin_b, MDRin_b, Read_b, Write_b, done_b, busy_b};

    typedef struct {
        logic        sel;
        logic        v;
        logic        w;
        logic [31:0] bus;
        logic [7:0]  exp;
    } vec_t;

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic idle_inputs();
        req_valid_a = 1'b0;
        req_write_a = 1'b0;
        req_valid_b = 1'b0;
        req_write_b = 1'b0;
    endtask

    // Holds a load request on A for cycles 0..5 of a 12-cycle window and records accepts/dones.
    task automatic b2b_loads(output logic [11:0] mar_mask, output logic [11:0] done_mask);
        mar_mask  = '0;
        done_mask = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clock);
            #1;
            req_valid_a = (cyc <= 5);
            req_write_a = 1'b0;
            bus         = 32'h20;
            @(negedge clock);
            if (MARin_a) mar_mask[cyc]  = 1'b1;
            if (done_a)  done_mask[cyc] = 1'b1;
        end
        req_valid_a = 1'b0;
    endtask

    vec_t        vecs [$];
    logic [11:0] mar_mask, done_mask;
    int          stray_done;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus    = 32'h0;
        idle_inputs();
        clear  = 1'b1;

        // Store on A (L=3), then a load on A with a request during busy, then a load on B (L=1)
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h40,       8'b1010_0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h12345678, 8'b0101_0001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0101});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0101});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0101});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0011});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b1000_0000});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h20,       8'b1010_0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_1001});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h99,       8'b0000_1001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0001_1001});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0011});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        8'b1000_0000});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h20,       8'b1010_0000});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        8'b0001_1001});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        8'b0000_0011});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        8'b1000_0000});

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_obs_a", {24'h0, obs_a}, 32'h80);
        check("reset_obs_b", {24'h0, obs_b}, 32'h80);
        check("reset_counts", {load_count_a, store_count_a, load_count_b, store_count_b}, 32'h0);
        @(posedge clock);
        #1 clear = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            idle_inputs();
            bus = vecs[i].bus;
            if (vecs[i].sel) begin
                req_valid_b = vecs[i].v;
                req_write_b = vecs[i].w;
            end else begin
                req_valid_a = vecs[i].v;
                req_write_a = vecs[i].w;
            end
            @(negedge clock);
            check($sformatf("vec%0d", i), {24'h0, (vecs[i].sel ? obs_b : obs_a)}, {24'h0, vecs[i].exp});
        end
        idle_inputs();

        check("store_ram_a_40", ram_a[8'h40], 32'h12345678);
        check("load_mdr_a", mdr_a, 32'hDEADBEEF);
        check("load_mdr_b", mdr_b, 32'hDEADBEEF);
        check("counts_a", {30'h0, load_count_a}, 32'd1);
        check("store_count_a", {30'h0, store_count_a}, 32'd1);
        check("load_count_b", {16'h0, load_count_b}, 32'd1);

        // req_valid held through a load: next accept only the cycle after DONE
        b2b_loads(mar_mask, done_mask);
        check("b2b_marin_cycles", {20'h0, mar_mask}, 32'h021);
        check("b2b_done_cycles", {20'h0, done_mask}, 32'h210);
        check("load_count_a_3", {30'h0, load_count_a}, 32'd3);
        b2b_loads(mar_mask, done_mask);
        check("load_count_a_sat", {30'h0, load_count_a}, 32'd3);

        // clear in the middle of a store's ACCESS phase
        @(posedge clock);
        #1;
        req_valid_a = 1'b1;
        req_write_a = 1'b1;
        bus         = 32'h40;
        @(posedge clock);
        #1;
        req_valid_a = 1'b0;
        bus         = 32'h55;
        @(posedge clock);
        #1;
        check("pre_clear_write", {31'h0, Write_a}, 32'd1);
        #1 clear = 1'b1;
        #1;
        check("clear_obs_a", {24'h0, obs_a}, 32'h80);
        check("clear_counts", {load_count_a, store_count_a, load_count_b, store_count_b}, 32'h0);
        @(posedge clock);
        #1 clear = 1'b0;
        stray_done = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clock);
            if (done_a || done_b || Write_a || Read_a || busy_a) stray_done++;
        end
        check("post_clear_quiet", stray_done, 32'd0);
        check("post_clear_store_count", {30'h0, store_count_a}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
